cascaded_bcd_down_timer: RTL and testbench

//   Parametrised successor to the fixed mod-10/mod-6/mod-3 decrementers. It is a chain of DIGITS
//   BCD down-counting digits, each with its own modulus, with borrow propagated digit to digit.

---
 rtl/cascaded_bcd_down_timer_if.sv | 30 +++
 rtl/cascaded_bcd_down_timer.sv | 148 ++++++++++++++
 tb/tb_cascaded_bcd_down_timer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/cascaded_bcd_down_timer_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : cascaded_bcd_down_timer_if                                  |
// | Brief    : control/preset inputs and BCD count/status outputs of timer |
// | Revision : 1.0                                                         |
// +------------------------------------------------------------------------+
interface cascaded_bcd_down_timer_if #(
  parameter int DIGITS = 4
);
  logic                  load;
  logic [4*DIGITS-1:0]   preset;
  logic                  start;
  logic                  pause;
  logic [4*DIGITS-1:0]   count;
  logic [1:0]            state;
  logic                  done;
  logic                  expired;
  logic [DIGITS-1:0]     zero_flag;

  modport master (
    output load, preset, start, pause,
    input  count, state, done, expired, zero_flag
  );

  modport slave (
    input  load, preset, start, pause,
    output count, state, done, expired, zero_flag
  );
endinterface
`default_nettype wire

// File: rtl/cascaded_bcd_down_timer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : cascaded_bcd_down_timer                                     |
// | Brief    : chain of BCD down-counting digits with per-digit modulus,   |
// |            tick prescaler, preset load and IDLE/RUN/PAUSE/DONE control.|
// |            Define AUTO_RELOAD_EN to reload the preset on expiry.       |
// | Revision : 1.0                                                         |
// +------------------------------------------------------------------------+
module cascaded_bcd_down_timer #(
  parameter int                  DIGITS   = 4,
  parameter logic [4*DIGITS-1:0] MOD_LIST = 16'h6A6A,
  parameter int                  TICK_DIV = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  cascaded_bcd_down_timer_if.slave tmr
);

  localparam int c_W  = 4 * DIGITS;
  localparam int c_PW = $clog2(TICK_DIV + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [c_W-1:0]    r_count;
  logic [c_W-1:0]    w_count_nxt;
  logic [c_W-1:0]    r_reload;
  logic [c_W-1:0]    w_reload_nxt;
  logic [c_PW-1:0]   r_presc;
  logic [c_PW-1:0]   w_presc_nxt;
  logic              r_done;
  logic              w_done_nxt;

  logic [c_W-1:0]    w_load_val;
  logic [c_W-1:0]    w_count_dec;
  logic [DIGITS-1:0] w_zero;
  logic [DIGITS:0]   w_low_zero;
  logic              w_tick;
  logic              w_count_zero;
  logic              w_count_one;

  // w_low_zero[i] is the borrow into digit i: every lower digit is already 0.
  assign w_low_zero[0] = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    logic [3:0] w_mod;
    logic [3:0] w_cur;
    logic [3:0] w_pre;

    assign w_mod = MOD_LIST[4*i +: 4];
    assign w_cur = r_count[4*i +: 4];
    assign w_pre = tmr.preset[4*i +: 4];

    assign w_zero[i]         = (w_cur == 4'd0);
    assign w_low_zero[i+1]   = w_low_zero[i] & w_zero[i];
    assign w_load_val[4*i +: 4] = (w_pre >= w_mod) ? (w_mod - 4'd1) : w_pre;
    assign w_count_dec[4*i +: 4] = !w_low_zero[i] ? w_cur
                                 : (w_zero[i] ? (w_mod - 4'd1) : (w_cur - 4'd1));
  end

  assign w_count_zero = w_low_zero[DIGITS];
  assign w_count_one  = (r_count == c_W'(1));
  assign w_tick       = (r_presc == c_PW'(TICK_DIV - 1));

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_reload <= '0;
      r_presc  <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_count  <= w_count_nxt;
      r_reload <= w_reload_nxt;
      r_presc  <= w_presc_nxt;
      r_done   <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_reload_nxt = r_reload;
    w_presc_nxt  = r_presc;
    w_done_nxt   = 1'b0;

    if (tmr.load) begin
      w_count_nxt  = w_load_val;
      w_reload_nxt = w_load_val;
      w_presc_nxt  = '0;
      w_state_nxt  = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (tmr.start && !w_count_zero) begin
            w_state_nxt = S_RUN;
          end
        end
        S_RUN: begin
          // pause wins over a coincident tick; the prescaler keeps its phase
          if (tmr.pause) begin
            w_state_nxt = S_PAUSE;
          end else begin
            w_presc_nxt = w_tick ? '0 : (r_presc + c_PW'(1));
            if (w_tick) begin
              w_count_nxt = w_count_dec;
              if (w_count_one) begin
                w_done_nxt = 1'b1;
`ifdef AUTO_RELOAD_EN
                w_count_nxt = r_reload;
`else
                w_state_nxt = S_DONE;
`endif
              end
            end
          end
        end
        S_PAUSE: begin
          if (tmr.start) begin
            w_state_nxt = S_RUN;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifndef AUTO_RELOAD_EN
  logic w_unused_reload;
  assign w_unused_reload = ^r_reload;
`endif

  assign tmr.count     = r_count;
  assign tmr.state     = r_state;
  assign tmr.done      = r_done;
  assign tmr.expired   = (r_state == S_DONE);
  assign tmr.zero_flag = w_zero;

endmodule
`default_nettype wire

// File: tb/tb_cascaded_bcd_down_timer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_cascaded_bcd_down_timer                                  |
// | Brief    : directed bench; dut_a uses TICK_DIV=1, dut_b TICK_DIV=4     |
// | Revision : 1.0                                                         |
// +------------------------------------------------------------------------+
module tb_cascaded_bcd_down_timer;

  logic clock;
  logic reset;
  int   vectors;
  int   miscompares;

  cascaded_bcd_down_timer_if #(.DIGITS(4)) ifa ();
  cascaded_bcd_down_timer_if #(.DIGITS(4)) ifb ();

  cascaded_bcd_down_timer #(.DIGITS(4), .MOD_LIST(16'h6A6A), .TICK_DIV(1)) dut_a (
    .clock (clock),
    .reset (reset),
    .tmr   (ifa.slave)
  );

  cascaded_bcd_down_timer #(.DIGITS(4), .MOD_LIST(16'h6A6A), .TICK_DIV(4)) dut_b (
    .clock (clock),
    .reset (reset),
    .tmr   (ifb.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    ifa.load = 1'b0; ifa.preset = '0; ifa.start = 1'b0; ifa.pause = 1'b0;
    ifb.load = 1'b0; ifb.preset = '0; ifb.start = 1'b0; ifb.pause = 1'b0;
    cyc(2);

    // activity before a mid-run reset
    reset = 1'b1;
    ifa.load = 1'b1; ifa.preset = 16'h1234;
    ifb.load = 1'b1; ifb.preset = 16'h0042;
    cyc(1);
    ifa.load = 1'b0; ifb.load = 1'b0;
    ifa.start = 1'b1; ifb.start = 1'b1;
    cyc(1);
    ifa.start = 1'b0; ifb.start = 1'b0;
    cyc(5);
    reset = 1'b0;
    cyc(1);
    chk("rst_count",   ifa.count,     16'h0000);
    chk("rst_state",   ifa.state,     2'b00);
    chk("rst_done",    ifa.done,      1'b0);
    chk("rst_expired", ifa.expired,   1'b0);
    chk("rst_zflag",   ifa.zero_flag, 4'hF);
    chk("rst_b_count", ifb.count,     16'h0000);
    reset = 1'b1;

    // clamp
    ifa.load = 1'b1; ifa.preset = 16'h0F7C;
    cyc(1);
    ifa.load = 1'b0;
    chk("clamp_count", ifa.count, 16'h0959);
    chk("clamp_state", ifa.state, 2'b00);
    chk("clamp_zflag", ifa.zero_flag, 4'h8);

    // cascade 0100 -> 0059
    ifa.load = 1'b1; ifa.preset = 16'h0100;
    cyc(1);
    ifa.load = 1'b0; ifa.start = 1'b1;
    cyc(1);
    ifa.start = 1'b0;
    chk("casc1_start_state", ifa.state, 2'b01);
    chk("casc1_start_count", ifa.count, 16'h0100);
    cyc(1);
    chk("casc1_count", ifa.count, 16'h0059);

    // cascade 1000 -> 0959
    ifa.load = 1'b1; ifa.preset = 16'h1000;
    cyc(1);
    ifa.load = 1'b0;
    chk("casc2_load_state", ifa.state, 2'b00);
    ifa.start = 1'b1;
    cyc(1);
    ifa.start = 1'b0;
    cyc(1);
    chk("casc2_count", ifa.count, 16'h0959);

`ifndef AUTO_RELOAD_EN
    // expire after 62 ticks from 01:02
    ifa.load = 1'b1; ifa.preset = 16'h0102;
    cyc(1);
    ifa.load = 1'b0; ifa.start = 1'b1;
    cyc(1);
    ifa.start = 1'b0;
    cyc(3);
    chk("exp_tick3", ifa.count, 16'h0059);
    cyc(58);
    chk("exp_tick61_count", ifa.count, 16'h0001);
    chk("exp_tick61_done",  ifa.done,  1'b0);
    cyc(1);
    chk("exp_tick62_count",   ifa.count,   16'h0000);
    chk("exp_tick62_done",    ifa.done,    1'b1);
    chk("exp_tick62_state",   ifa.state,   2'b11);
    chk("exp_tick62_expired", ifa.expired, 1'b1);
    cyc(1);
    chk("exp_done_pulse_end", ifa.done, 1'b0);
    ifa.start = 1'b1; ifa.pause = 1'b1;
    cyc(1);
    ifa.start = 1'b0; ifa.pause = 1'b0;
    chk("exp_start_ignored_state", ifa.state, 2'b11);
    chk("exp_start_ignored_count", ifa.count, 16'h0000);

    // start at zero is ignored
    ifa.load = 1'b1; ifa.preset = 16'h0000;
    cyc(1);
    ifa.load = 1'b0;
    chk("zero_load_expired", ifa.expired, 1'b0);
    ifa.start = 1'b1;
    cyc(1);
    ifa.start = 1'b0;
    chk("zero_start_state", ifa.state, 2'b00);
`else
    // auto reload every 3 ticks
    ifa.load = 1'b1; ifa.preset = 16'h0003;
    cyc(1);
    ifa.load = 1'b0; ifa.start = 1'b1;
    cyc(1);
    ifa.start = 1'b0;
    cyc(2);
    chk("ar_tick2_count", ifa.count, 16'h0001);
    chk("ar_tick2_done",  ifa.done,  1'b0);
    cyc(1);
    chk("ar_tick3_count",   ifa.count,   16'h0003);
    chk("ar_tick3_done",    ifa.done,    1'b1);
    chk("ar_tick3_state",   ifa.state,   2'b01);
    chk("ar_tick3_expired", ifa.expired, 1'b0);
    cyc(1);
    chk("ar_tick4_count", ifa.count, 16'h0002);
    chk("ar_tick4_done",  ifa.done,  1'b0);
    cyc(2);
    chk("ar_tick6_count", ifa.count, 16'h0003);
    chk("ar_tick6_done",  ifa.done,  1'b1);
    chk("ar_tick6_state", ifa.state, 2'b01);
`endif

    // pause with TICK_DIV=4: prescaler held at 2, so resume decrements after 2 cycles
    ifb.load = 1'b1; ifb.preset = 16'h0005;
    cyc(1);
    ifb.load = 1'b0; ifb.start = 1'b1;
    cyc(1);
    ifb.start = 1'b0;
    cyc(2);
    ifb.pause = 1'b1;
    cyc(1);
    ifb.pause = 1'b0;
    chk("pause_state", ifb.state, 2'b10);
    cyc(10);
    chk("pause_hold_count", ifb.count, 16'h0005);
    chk("pause_hold_state", ifb.state, 2'b10);
    ifb.start = 1'b1;
    cyc(1);
    ifb.start = 1'b0;
    chk("resume_state", ifb.state, 2'b01);
    chk("resume_c0",    ifb.count, 16'h0005);
    cyc(1);
    chk("resume_c1",    ifb.count, 16'h0005);
    cyc(1);
    chk("resume_c2",    ifb.count, 16'h0004);
    cyc(3);
    chk("resume_c5",    ifb.count, 16'h0004);
    cyc(1);
    chk("resume_c6",    ifb.count, 16'h0003);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
